// File: rtl/alu_cmd_sequencer.sv
// Handshaked command front-end for the 8-bit ALU: issues operands, waits ALU_LAT edges,
// captures result/flags into a response FIFO. Define ALU_SEQ_ZCHECK_EN to add the zchk_err output.
module alu_cmd_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overF,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overF,
  output logic             busy
`ifdef ALU_SEQ_ZCHECK_EN
  ,
  output logic             zchk_err
`endif
);

  // state   | meaning
  // IDLE    | ready for a command when the response FIFO has room
  // WAIT    | ALU inputs driven, counting down the ALU latency
  // CAPTURE | ALU outputs valid this edge, push them into the FIFO
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int EW  = WIDTH + 3;
  localparam int WCW = 3;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [EW-1:0]    mem [RSP_DEPTH];
  logic             accept, push, pop;

  assign accept = cmd_valid && cmd_ready;
  assign pop    = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = (ALU_LAT == 0) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wcnt == WCW'(1)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    push      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = (count < CW'(RSP_DEPTH));
        busy      = 1'b0;
      end
      S_CAPTURE: push = 1'b1;
      default: ;
    endcase
  end

  // ALU drive registers hold the last command until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_inA <= '0;
      alu_inB <= '0;
      alu_sel <= '0;
      wcnt    <= '0;
    end else if (accept) begin
      alu_inA <= cmd_a;
      alu_inB <= cmd_b;
      alu_sel <= cmd_sel;
      wcnt    <= WCW'(ALU_LAT);
    end else if (state_q == S_WAIT) begin
      wcnt    <= wcnt - WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {alu_result, alu_zero, alu_carry, alu_overF};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign rsp_valid = (count != '0);
  assign {rsp_result, rsp_zero, rsp_carry, rsp_overF} = mem[rd_ptr];

`ifdef ALU_SEQ_ZCHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      zchk_err <= 1'b0;
    else if (push && (alu_zero != (alu_result == '0)))
      zchk_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: three instances (ALU_LAT 1, 0, 3) driven one at a time.
// Covers the zchk_err output when built with ALU_SEQ_ZCHECK_EN.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance with ALU_LAT = 1 (registered stub ALU) ----------------
  logic       d1_cmd_valid = 0, d1_cmd_ready, d1_rsp_ready = 0, d1_rsp_valid, d1_busy;
  logic [7:0] d1_cmd_a = 0, d1_cmd_b = 0, d1_inA, d1_inB, d1_rsp_result;
  logic [2:0] d1_cmd_sel = 0, d1_sel;
  logic [7:0] d1_alu_result = '0;
  logic       d1_alu_zero = 0, d1_alu_carry = 0, d1_alu_overF = 0;
  logic       d1_rsp_zero, d1_rsp_carry, d1_rsp_overF;
  logic       zbad = 1'b0;

  // ---------------- instance with ALU_LAT = 0 (combinational stub ALU) ----------------
  logic       d0_cmd_valid = 0, d0_cmd_ready, d0_rsp_ready = 0, d0_rsp_valid, d0_busy;
  logic [7:0] d0_cmd_a = 0, d0_cmd_b = 0, d0_inA, d0_inB, d0_rsp_result, d0_alu_result;
  logic [2:0] d0_cmd_sel = 0, d0_sel;
  logic       d0_alu_zero, d0_alu_carry, d0_alu_overF, d0_rsp_zero, d0_rsp_carry, d0_rsp_overF;

  // ---------------- instance with ALU_LAT = 3 ----------------
  logic       d3_cmd_valid = 0, d3_cmd_ready, d3_rsp_ready = 0, d3_rsp_valid, d3_busy;
  logic [7:0] d3_cmd_a = 0, d3_cmd_b = 0, d3_inA, d3_inB, d3_rsp_result, d3_alu_result;
  logic [2:0] d3_cmd_sel = 0, d3_sel;
  logic       d3_alu_zero, d3_alu_carry, d3_alu_overF, d3_rsp_zero, d3_rsp_carry, d3_rsp_overF;

`ifdef ALU_SEQ_ZCHECK_EN
  logic d1_zchk, d0_zchk, d3_zchk;
`endif

  // Stub ALU: {result, zero, carry, overflow}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    logic [8:0] w;
    logic       v;
    w = '0;
    v = 1'b0;
    case (s)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      3'd2: w = {1'b0, a & b};
      3'd3: w = {1'b0, a | b};
      3'd4: w = {1'b0, a ^ b};
      3'd5: w = {1'b0, ~a};
      3'd6: w = {a, 1'b0};
      default: w = {1'b0, b};
    endcase
    return {w[7:0], (w[7:0] == 8'h00), w[8], v};
  endfunction

  always @(posedge clk) begin
    if (zbad) {d1_alu_result, d1_alu_zero, d1_alu_carry, d1_alu_overF} <= {8'h05, 1'b1, 1'b0, 1'b0};
    else      {d1_alu_result, d1_alu_zero, d1_alu_carry, d1_alu_overF} <= alu_f(d1_inA, d1_inB, d1_sel);
  end
  assign {d0_alu_result, d0_alu_zero, d0_alu_carry, d0_alu_overF} = alu_f(d0_inA, d0_inB, d0_sel);
  assign {d3_alu_result, d3_alu_zero, d3_alu_carry, d3_alu_overF} = alu_f(d3_inA, d3_inB, d3_sel);

  alu_cmd_sequencer #(.WIDTH(8), .SEL_W(3), .ALU_LAT(1), .RSP_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
    .cmd_a(d1_cmd_a), .cmd_b(d1_cmd_b), .cmd_sel(d1_cmd_sel),
    .alu_inA(d1_inA), .alu_inB(d1_inB), .alu_sel(d1_sel),
    .alu_result(d1_alu_result), .alu_zero(d1_alu_zero), .alu_carry(d1_alu_carry), .alu_overF(d1_alu_overF),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_result),
    .rsp_zero(d1_rsp_zero), .rsp_carry(d1_rsp_carry), .rsp_overF(d1_rsp_overF), .busy(d1_busy)
`ifdef ALU_SEQ_ZCHECK_EN
    , .zchk_err(d1_zchk)
`endif
  );

  alu_cmd_sequencer #(.WIDTH(8), .SEL_W(3), .ALU_LAT(0), .RSP_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(d0_cmd_valid), .cmd_ready(d0_cmd_ready),
    .cmd_a(d0_cmd_a), .cmd_b(d0_cmd_b), .cmd_sel(d0_cmd_sel),
    .alu_inA(d0_inA), .alu_inB(d0_inB), .alu_sel(d0_sel),
    .alu_result(d0_alu_result), .alu_zero(d0_alu_zero), .alu_carry(d0_alu_carry), .alu_overF(d0_alu_overF),
    .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready), .rsp_result(d0_rsp_result),
    .rsp_zero(d0_rsp_zero), .rsp_carry(d0_rsp_carry), .rsp_overF(d0_rsp_overF), .busy(d0_busy)
`ifdef ALU_SEQ_ZCHECK_EN
    , .zchk_err(d0_zchk)
`endif
  );

  alu_cmd_sequencer #(.WIDTH(8), .SEL_W(3), .ALU_LAT(3), .RSP_DEPTH(4)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready),
    .cmd_a(d3_cmd_a), .cmd_b(d3_cmd_b), .cmd_sel(d3_cmd_sel),
    .alu_inA(d3_inA), .alu_inB(d3_inB), .alu_sel(d3_sel),
    .alu_result(d3_alu_result), .alu_zero(d3_alu_zero), .alu_carry(d3_alu_carry), .alu_overF(d3_alu_overF),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_result(d3_rsp_result),
    .rsp_zero(d3_rsp_zero), .rsp_carry(d3_rsp_carry), .rsp_overF(d3_rsp_overF), .busy(d3_busy)
`ifdef ALU_SEQ_ZCHECK_EN
    , .zchk_err(d3_zchk)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One command through dut1; returns captured response, negedges from accept to rsp_valid, busy cycles
  task automatic run_d1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                        output logic [10:0] got, output int lat, output int bcyc);
    int n;
    got  = '0;
    lat  = -1;
    bcyc = 0;
    @(negedge clk);
    d1_cmd_a = a; d1_cmd_b = b; d1_cmd_sel = s; d1_cmd_valid = 1'b1;
    n = 0;
    while (!d1_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    d1_cmd_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (d1_busy) bcyc++;
      if (d1_rsp_valid) begin
        lat = i;
        got = {d1_rsp_result, d1_rsp_zero, d1_rsp_carry, d1_rsp_overF};
        break;
      end
      @(negedge clk);
    end
    d1_rsp_ready = 1'b1;
    @(negedge clk);
    d1_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  sel;
    logic [10:0] exp;   // {result, zero, carry, overF}
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [10:0] got;
    int lat, bcyc;

    vecs[0]  = '{8'h33, 8'hA7, 3'd1, {8'h8C, 1'b0, 1'b1, 1'b1}};
    vecs[1]  = '{8'h80, 8'h80, 3'd0, {8'h00, 1'b1, 1'b1, 1'b1}};
    vecs[2]  = '{8'h12, 8'h34, 3'd0, {8'h46, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{8'hFF, 8'h01, 3'd0, {8'h00, 1'b1, 1'b1, 1'b0}};
    vecs[4]  = '{8'h7F, 8'h01, 3'd0, {8'h80, 1'b0, 1'b0, 1'b1}};
    vecs[5]  = '{8'h55, 8'h55, 3'd1, {8'h00, 1'b1, 1'b0, 1'b0}};
    vecs[6]  = '{8'hF0, 8'h3C, 3'd2, {8'h30, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{8'hF0, 8'h0F, 3'd3, {8'hFF, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{8'hAA, 8'hAA, 3'd4, {8'h00, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{8'h0F, 8'h00, 3'd5, {8'hF0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{8'h81, 8'h00, 3'd6, {8'h02, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{8'h00, 8'h9C, 3'd7, {8'h9C, 1'b0, 1'b0, 1'b0}};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(d1_rsp_valid), 32'd0);
    check("reset_rsp_data", 32'({d1_rsp_result, d1_rsp_zero, d1_rsp_carry, d1_rsp_overF}), 32'd0);
    check("reset_busy", 32'(d1_busy), 32'd0);
    check("reset_alu_drive", 32'({d1_inA, d1_inB, d1_sel}), 32'd0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 32'(d1_cmd_ready), 32'd1);

    // ---- table-driven commands, ALU_LAT = 1 ----
    foreach (vecs[k]) begin
      run_d1(vecs[k].a, vecs[k].b, vecs[k].sel, got, lat, bcyc);
      check($sformatf("vec%0d_rsp", k), 32'(got), 32'(vecs[k].exp));
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'd3);
      check($sformatf("vec%0d_busy_cycles", k), 32'(bcyc), 32'd2);
    end
    check("alu_inputs_hold", 32'({d1_inA, d1_inB, d1_sel}), 32'({8'h00, 8'h9C, 3'd7}));

    // ---- back-pressure: 6 commands, consumer stalled for 20 cycles ----
    begin
      int acc_n, pop_n, first_pop, fifth_acc;
      logic [7:0] pops[6];
      acc_n = 0; pop_n = 0; first_pop = -1; fifth_acc = -1;
      for (int cyc = 0; cyc < 80 && pop_n < 6; cyc++) begin
        @(negedge clk);
        if (cyc == 20) begin
          check("bp_accepts_while_stalled", 32'(acc_n), 32'd4);
          check("bp_ready_low_when_full", 32'(d1_cmd_ready), 32'd0);
          d1_rsp_ready = 1'b1;
        end
        d1_cmd_valid = (acc_n < 6);
        d1_cmd_a     = 8'h00;
        d1_cmd_sel   = 3'd7;
        d1_cmd_b     = 8'(8'hA1 + acc_n);
        if (d1_rsp_valid && d1_rsp_ready) begin
          if (pop_n == 0) first_pop = cyc;
          if (pop_n < 6) pops[pop_n] = d1_rsp_result;
          pop_n++;
        end
        if (d1_cmd_valid && d1_cmd_ready) begin
          if (acc_n == 4) fifth_acc = cyc;
          acc_n++;
        end
      end
      @(negedge clk);
      d1_cmd_valid = 1'b0;
      d1_rsp_ready = 1'b0;
      check("bp_pop_count", 32'(pop_n), 32'd6);
      check("bp_fifth_after_first_pop", 32'(fifth_acc), 32'(first_pop + 1));
      for (int i = 0; i < 6 && i < pop_n; i++)
        check($sformatf("bp_order%0d", i), 32'(pops[i]), 32'(8'hA1 + i));
    end

    // ---- continuous traffic, ALU_LAT = 0, with a push/pop collision ----
    begin
      logic [7:0] cont[6];
      logic [7:0] pops[6];
      int acc_n, pop_n, last_acc, gap_bad;
      cont[0] = 8'h10; cont[1] = 8'h21; cont[2] = 8'h32;
      cont[3] = 8'h43; cont[4] = 8'h54; cont[5] = 8'h65;
      acc_n = 0; pop_n = 0; last_acc = -1; gap_bad = 0;
      for (int cyc = 0; cyc < 60 && pop_n < 6; cyc++) begin
        @(negedge clk);
        d0_rsp_ready = (cyc >= 3);
        d0_cmd_valid = (acc_n < 6);
        d0_cmd_a     = 8'h00;
        d0_cmd_sel   = 3'd7;
        d0_cmd_b     = (acc_n < 6) ? cont[acc_n] : 8'h00;
        if (cyc == 4) check("collision_head", 32'({d0_rsp_valid, d0_rsp_result}), 32'({1'b1, 8'h21}));
        if (d0_rsp_valid && d0_rsp_ready) begin
          if (pop_n < 6) pops[pop_n] = d0_rsp_result;
          pop_n++;
        end
        if (d0_cmd_valid && d0_cmd_ready) begin
          if (last_acc >= 0 && (cyc - last_acc) != 2) gap_bad++;
          last_acc = cyc;
          acc_n++;
        end
      end
      @(negedge clk);
      d0_cmd_valid = 1'b0;
      d0_rsp_ready = 1'b0;
      check("cont_accepts", 32'(acc_n), 32'd6);
      check("cont_accept_gap", 32'(gap_bad), 32'd0);
      check("cont_pop_count", 32'(pop_n), 32'd6);
      for (int i = 0; i < 6 && i < pop_n; i++)
        check($sformatf("cont_order%0d", i), 32'(pops[i]), 32'(cont[i]));
      @(negedge clk);
      check("cont_drained", 32'(d0_rsp_valid), 32'd0);
    end

    // ---- reset during WAIT, ALU_LAT = 3, one response queued ----
    begin
      int n;
      bit seen;
      @(negedge clk);
      d3_cmd_a = 8'h01; d3_cmd_b = 8'h02; d3_cmd_sel = 3'd0; d3_cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d3_cmd_valid = 1'b0;
      n = 0;
      while (!d3_rsp_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("rst_first_queued", 32'({d3_rsp_valid, d3_rsp_result}), 32'({1'b1, 8'h03}));
      d3_cmd_a = 8'h44; d3_cmd_b = 8'h55; d3_cmd_sel = 3'd3; d3_cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d3_cmd_valid = 1'b0;
      check("rst_in_wait", 32'({d3_busy, d3_inA}), 32'({1'b1, 8'h44}));
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("rst_rsp_valid", 32'(d3_rsp_valid), 32'd0);
      check("rst_alu_drive", 32'({d3_inA, d3_inB, d3_sel}), 32'd0);
      check("rst_busy", 32'(d3_busy), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (d3_rsp_valid || d3_busy) seen = 1'b1;
      end
      check("rst_no_stale_rsp", 32'(seen), 32'd0);
      check("rst_ready_again", 32'(d3_cmd_ready), 32'd1);
    end

`ifdef ALU_SEQ_ZCHECK_EN
    // ---- zero-flag consistency check ----
    run_d1(8'h01, 8'h02, 3'd0, got, lat, bcyc);
    check("zchk_clear_on_good", 32'(d1_zchk), 32'd0);
    zbad = 1'b1;
    run_d1(8'h10, 8'h20, 3'd0, got, lat, bcyc);
    zbad = 1'b0;
    check("zchk_bad_rsp_unmodified", 32'(got), 32'({8'h05, 1'b1, 1'b0, 1'b0}));
    check("zchk_sets", 32'(d1_zchk), 32'd1);
    run_d1(8'h12, 8'h34, 3'd0, got, lat, bcyc);
    check("zchk_good_after_bad", 32'(got), 32'({8'h46, 1'b0, 1'b0, 1'b0}));
    check("zchk_sticky", 32'(d1_zchk), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("zchk_reset", 32'(d1_zchk), 32'd0);
    @(negedge clk);
    reset = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
